fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage that drives the word address of the 32-bit synchronous instruction ROM and turns its returned data into a valid/ready instruction stream for decode. The ROM registers its address on the clock edge, so data appears one cycle later and the ROM has no enable. This block therefore holds the presented address across stalls and tags each returned word with its PC. It also handles redirects from execute, squashing wrong-path words.

## Interface
Parameters:
- `DEPTH`, 512: ROM depth in 32-bit words.
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `ADDR_WIDTH` (localparam): `$clog2(DEPTH)`.

Ports:
- `i_clk`  in  1  clock. One clock only; everything runs on the rising edge.
- `i_rst`  in  1  reset. Asynchronous, active-high.
- `o_rom_addr`  out  ADDR_WIDTH  word address to the ROM, equal to `sel_pc[ADDR_WIDTH+1:2]`.
- `i_rom_data`  in  32  ROM read data for the address presented at the previous edge.
- `i_redirect`  in  1  redirect request from execute.
- `i_redirect_pc`  in  32  redirect target byte address.
- `o_valid`  out  1  an instruction is offered to decode.
- `i_ready`  in  1  decode accepts the offered instruction.
- `o_instr`  out  32  instruction word.
- `o_pc`  out  32  byte PC of `o_instr`, with bits [1:0] always 0.

## Operation
State:
- `r_fetch_pc`: next sequential PC.
- `r_pc_d`: PC of the word currently on `i_rom_data`.
- `r_valid_d`: the word on `i_rom_data` is valid.

Combinational signals (default build):
- `stall = r_valid_d & ~i_ready & ~i_redirect`.
- `sel_pc` priority: `i_redirect` gives `{i_redirect_pc[31:2],2'b00}`; otherwise `stall` gives `r_pc_d`; otherwise `r_fetch_pc`.
- `o_valid = r_valid_d & ~i_redirect`. A redirect squashes the word currently offered.
- `o_instr = i_rom_data`; `o_pc = r_pc_d`.

Each edge:
- `r_pc_d <= sel_pc`
- `r_fetch_pc <= sel_pc + 4` (32-bit arithmetic, wraps modulo 2^32)
- `r_valid_d <= 1`

Behaviour:
- On a stall the same address is re-presented, so ROM output and `o_pc` stay stable until the word is accepted.
- PC bits above `ADDR_WIDTH+1` are carried in `o_pc` but truncated in `o_rom_addr`, so the ROM address wraps modulo DEPTH.
- A redirect arriving during a stall wins: the stalled word is dropped and the target is fetched.

Reset values:
- `r_fetch_pc = RESET_PC`, `r_pc_d = RESET_PC`, `r_valid_d = 0`.
- Resulting outputs: `o_valid = 0`, `o_pc = RESET_PC`.
- `o_rom_addr` is the `RESET_PC` word throughout reset.
- Asserting reset mid-stream drops the offered word immediately, since `o_valid` falls asynchronously.

## Timing
- Redirect asserted in cycle N: `o_valid = 0` in N; the target word is offered in N+1 (default build).
- Sustained `i_ready = 1`: one instruction per cycle, consecutive PCs.
- First instruction after reset deassertion: offered one cycle after the first edge.
- Default build has combinational paths `i_ready` / `i_redirect` → `o_rom_addr` and `i_redirect` → `o_valid`.

## Configuration
- `FETCH_SKID_EN` undefined: behaviour exactly as above.
- `FETCH_SKID_EN` defined: a 3-entry FIFO of {pc, instr} sits between ROM and decode.
  - `o_valid`, `o_instr` and `o_pc` come from the FIFO head and are registered.
  - The ROM issue decision uses only registered state: issue when `count + inflight <= 2`, otherwise hold the address.
  - A returned word is pushed when `inflight` was set.
  - Redirect clears the FIFO and `inflight`, and issues the target immediately. The target is offered two cycles after the redirect.
  - Throughput is 1/cycle when `i_ready` stays high. Total occupancy never exceeds 3, and no word is lost or duplicated.
  - This build removes the `i_ready` → `o_rom_addr` path.

## Test plan
- Reset release, `RESET_PC = 0`, `i_ready` held 1, ROM word k = k → `o_pc` 0,4,8,… with `o_instr` 0,1,2,…, one per cycle.
- Deassert `i_ready` for 3 cycles while `o_pc = 8` → `o_pc` stays 8 with instr 2; after release the next outputs are 12 and then 16, with no skips or duplicates.
- Redirect to `0x40` while `o_pc = 0x10` → `o_valid = 0` that cycle; next accepted `o_pc = 0x40`, instr 16 (add 1 cycle with `FETCH_SKID_EN`).
- Redirect to `0x43` during a stall → next `o_pc = 0x40`; the stalled word is never accepted.
- DEPTH = 512, sequential fetch past `0x7FC` → `o_pc = 0x800`, `o_rom_addr = 0`, instr equals word 0.
- Assert `i_rst` mid-stream, asynchronously between edges → `o_valid` drops before the next edge; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous instruction ROM, tags returned words with their PC
// and offers them to decode over valid/ready. Optional FETCH_SKID_EN adds a 3-entry output FIFO.
module fetch_stage #(
    parameter int          DEPTH      = 512,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    localparam int         ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [31:0]           i_rom_data,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_instr,
    output logic [31:0]           o_pc
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] redirect_target;
    logic [31:0] sel_pc;

    assign redirect_target = {i_redirect_pc[31:2], 2'b00};
    assign o_rom_addr      = sel_pc[ADDR_WIDTH+1:2];

`ifdef FETCH_SKID_EN

    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_q,    inflight_d;
    logic [1:0]  count_q,       count_d;
    logic [31:0] slot_pc_q    [3];
    logic [31:0] slot_pc_d    [3];
    logic [31:0] slot_instr_q [3];
    logic [31:0] slot_instr_d [3];

    logic        issue;
    logic        push;
    logic        pop;
    logic [1:0]  eff_count;

    // Issue decision sees only registered occupancy, so i_ready never reaches the ROM address.
    assign issue     = ({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2;
    assign push      = inflight_q;
    assign pop       = (count_q != 2'd0) & i_ready;
    assign eff_count = count_q - {1'b0, pop};

    always_comb begin
        if (i_rst) begin
            sel_pc = RESET_PC_ALIGNED;
        end else if (i_redirect) begin
            sel_pc = redirect_target;
        end else begin
            sel_pc = fetch_pc_q;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        count_d       = count_q;
        if (i_redirect) begin
            count_d       = 2'd0;
            inflight_d    = 1'b1;
            inflight_pc_d = redirect_target;
            fetch_pc_d    = redirect_target + 32'd4;
        end else begin
            count_d    = count_q + {1'b0, push} - {1'b0, pop};
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q    <= RESET_PC_ALIGNED;
            inflight_pc_q <= RESET_PC_ALIGNED;
            inflight_q    <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
        end
    end

    // Shift-register FIFO: slot 0 is always the head, so outputs come straight from flops.
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        always_comb begin
            slot_pc_d[gi]    = slot_pc_q[gi];
            slot_instr_d[gi] = slot_instr_q[gi];
            if (!i_redirect) begin
                if (pop) begin
                    if (gi < 2) begin
                        slot_pc_d[gi]    = slot_pc_q[(gi < 2) ? gi + 1 : gi];
                        slot_instr_d[gi] = slot_instr_q[(gi < 2) ? gi + 1 : gi];
                    end
                end
                if (push && (eff_count == 2'(gi))) begin
                    slot_pc_d[gi]    = inflight_pc_q;
                    slot_instr_d[gi] = i_rom_data;
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                slot_pc_q[gi]    <= RESET_PC_ALIGNED;
                slot_instr_q[gi] <= 32'd0;
            end else begin
                slot_pc_q[gi]    <= slot_pc_d[gi];
                slot_instr_q[gi] <= slot_instr_d[gi];
            end
        end
    end

    assign o_valid = (count_q != 2'd0);
    assign o_instr = slot_instr_q[0];
    assign o_pc    = slot_pc_q[0];

`else

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q,       pc_d;
    logic        valid_q,    valid_d;
    logic        stall;

    assign stall = valid_q & ~i_ready & ~i_redirect;

    // The ROM has no enable, so a stall re-presents the offered word's address to hold its data.
    always_comb begin
        if (i_rst) begin
            sel_pc = RESET_PC_ALIGNED;
        end else if (i_redirect) begin
            sel_pc = redirect_target;
        end else if (stall) begin
            sel_pc = pc_q;
        end else begin
            sel_pc = fetch_pc_q;
        end
    end

    always_comb begin
        pc_d       = sel_pc;
        fetch_pc_d = sel_pc + 32'd4;
        valid_d    = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC_ALIGNED;
            pc_q       <= RESET_PC_ALIGNED;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign o_valid = valid_q & ~i_redirect;
    assign o_instr = i_rom_data;
    assign o_pc    = pc_q;

`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage (default build): the expected accepted instruction
// stream is generated from PC rules and ROM contents, and a negedge monitor compares handshakes.
module tb_fetch_stage;

    localparam int          DEPTH    = 512;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          AW       = $clog2(DEPTH);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW-1:0] o_rom_addr;
    logic [31:0]   i_rom_data = 32'd0;
    logic          i_redirect = 1'b0;
    logic [31:0]   i_redirect_pc = 32'd0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_instr       (o_instr),
        .o_pc          (o_pc)
    );

    always #5 i_clk = ~i_clk;

    logic [31:0] rom_mem [DEPTH];
    always @(posedge i_clk) i_rom_data <= rom_mem[o_rom_addr];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          checks   = 0;
    int          failures = 0;
    int          edges    = 0;
    int          txns     = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return (pc >> 2) % DEPTH;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = rom_mem[int'(word_of(pc))];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, expv);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(mk(model_pc));
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = {pc[31:2], 2'b00};
        refill();
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        refill();
    endtask

    task automatic apply(input logic r, input logic rd, input logic [31:0] tgt);
        i_ready       = r;
        i_redirect    = rd;
        i_redirect_pc = tgt;
        if (rd) restart(tgt);
    endtask

    task automatic run_until(input logic [31:0] pc);
        int n = 0;
        while (exp_q[0].pc != pc && n < 60) begin
            apply(1'b1, 1'b0, 32'd0);
            tick();
            n++;
        end
        if (n >= 60) begin
            failures++;
            $display("FAIL reach_pc actual=%08h expected=%08h", exp_q[0].pc, pc);
        end
    endtask

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) edges <= 0;
        else if (edges < 2) edges <= edges + 1;
    end

    // Decisions for a cycle are made here, before the handshake edge that follows.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            logic        ev;
            logic [31:0] ea;
            ev = (edges >= 1) && !i_redirect;
            chk("valid", {31'd0, o_valid}, {31'd0, ev});
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty actual=0 expected=nonzero");
            end else begin
                if (i_redirect) ea = {i_redirect_pc[31:2], 2'b00};
                else if (ev && i_ready) ea = exp_q[0].pc + 32'd4;
                else ea = exp_q[0].pc;
                chk("rom_addr", {{(32-AW){1'b0}}, o_rom_addr}, word_of(ea));
                if (o_valid && i_ready && !i_redirect) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    txns++;
                    $display("txn %0d pc=%08h instr=%08h", txns, o_pc, o_instr);
                    chk("pc", o_pc, e.pc);
                    chk("instr", o_instr, e.instr);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) rom_mem[k] = k;
        restart(RESET_PC);

        // Reset state, including address pinned even with a redirect request present.
        apply(1'b1, 1'b0, 32'd0);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0100;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_pc", o_pc, RESET_PC);
        chk("rst_addr", {{(32-AW){1'b0}}, o_rom_addr}, word_of(RESET_PC));
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Stream, then a 3-cycle stall on pc 8.
        run_until(32'h8);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 32'd0);
            tick();
        end
        apply(1'b1, 1'b0, 32'd0);

        // Redirect while 0x10 is offered.
        run_until(32'h10);
        apply(1'b1, 1'b1, 32'h40);
        tick();
        apply(1'b1, 1'b0, 32'd0);
        tick();

        // Redirect with unaligned target during a stall.
        apply(1'b0, 1'b0, 32'd0);
        tick();
        apply(1'b0, 1'b1, 32'h43);
        tick();
        apply(1'b1, 1'b0, 32'd0);
        repeat (3) tick();

        // ROM wrap past 0x7FC and 32-bit PC wrap.
        apply(1'b1, 1'b1, 32'h7F0);
        tick();
        apply(1'b1, 1'b0, 32'd0);
        repeat (8) tick();
        apply(1'b1, 1'b1, 32'hFFFF_FFF4);
        tick();
        apply(1'b1, 1'b0, 32'd0);
        repeat (6) tick();

        // Randomized ready/redirect traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        rd;
            logic [31:0] tgt;
            r   = ($urandom % 4) != 0;
            rd  = ($urandom % 12) == 0;
            tgt = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 32'h0FFF));
            apply(r, rd, tgt);
            tick();
        end

        // Asynchronous reset between edges.
        apply(1'b1, 1'b0, 32'd0);
        tick();
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("async_rst_addr", {{(32-AW){1'b0}}, o_rom_addr}, word_of(RESET_PC));
        restart(RESET_PC);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        apply(1'b1, 1'b0, 32'd0);
        repeat (10) tick();

        if (txns < 100) begin
            failures++;
            $display("FAIL txn_count actual=%0d expected=>=100", txns);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
